// File: rtl/trigger_buffer_reader_if.sv
// Point-stream and buffer-read bundle between the capture RAM, the reader and the plotter.
// master = reader side, slave = environment (RAM, trigger block, plotter).
interface trigger_buffer_reader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned Y_W    = 10
) ();
    logic              capture_done;
    logic              frame_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              sample_valid;
    logic              sample_ready;
    logic [ADDR_W-1:0] sample_x;
    logic [Y_W-1:0]    sample_y;
    logic              busy;
    logic              overrun;

    modport master (
        input  capture_done, frame_start, rd_data, sample_ready,
        output rd_addr, sample_valid, sample_x, sample_y, busy, overrun
    );

    modport slave (
        output capture_done, frame_start, rd_data, sample_ready,
        input  rd_addr, sample_valid, sample_x, sample_y, busy, overrun
    );
endinterface

// File: rtl/trigger_buffer_reader.sv
// Streams a completed trigger capture out as (x, y) plot points, one readout per display frame.
// Define TRIG_READ_INVERT_Y_EN to invert the sample before scaling (larger samples drawn higher).
module trigger_buffer_reader #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned Y_SHIFT  = 3,
    parameter int unsigned Y_OFFSET = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    trigger_buffer_reader_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_FETCH,
        S_LOAD,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] w_rd_addr_nxt;
    logic [ADDR_W-1:0] r_sample_x;
    logic [ADDR_W-1:0] w_sample_x_nxt;
    logic [Y_W-1:0]    r_sample_y;
    logic [Y_W-1:0]    w_sample_y_nxt;
    logic              r_sample_valid;
    logic              w_valid_nxt;
    logic              r_busy;
    logic              r_pending;
    logic              w_pending_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;

    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] w_shifted;
    logic [Y_W-1:0]    w_y;
    logic              w_handshake;
    logic              w_mid_stream;

    // Row scaling; the sum wraps at Y_W bits by construction.
`ifdef TRIG_READ_INVERT_Y_EN
    assign w_src = ~bus.rd_data;
`else
    assign w_src = bus.rd_data;
`endif
    assign w_shifted   = w_src >> Y_SHIFT;
    assign w_y         = Y_W'(Y_OFFSET) + Y_W'(w_shifted);
    assign w_handshake = r_sample_valid & bus.sample_ready;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_rd_addr_nxt  = r_rd_addr;
        w_valid_nxt    = r_sample_valid;
        w_sample_x_nxt = r_sample_x;
        w_sample_y_nxt = r_sample_y;
        w_pending_nxt  = r_pending;
        w_overrun_nxt  = r_overrun;
        w_mid_stream   = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                         (r_state == S_PRESENT) || (r_state == S_DONE);

        // One capture can be queued behind the running readout; a second one is dropped.
        if (w_mid_stream && bus.capture_done) begin
            if (r_pending) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_pending_nxt = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (bus.capture_done) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.frame_start) begin
                    w_state_nxt   = S_FETCH;
                    w_addr_nxt    = '0;
                    w_rd_addr_nxt = '0;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_sample_x_nxt = r_addr;
                w_sample_y_nxt = w_y;
                w_valid_nxt    = 1'b1;
                w_state_nxt    = S_PRESENT;
            end
            S_PRESENT: begin
                if (w_handshake) begin
                    w_valid_nxt = 1'b0;
                    if (r_addr == LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_addr_nxt    = r_addr + ADDR_W'(1);
                        w_rd_addr_nxt = r_addr + ADDR_W'(1);
                        w_state_nxt   = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                // Includes a capture arriving in this very cycle.
                if (w_pending_nxt) begin
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = S_ARMED;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_rd_addr      <= '0;
            r_sample_x     <= '0;
            r_sample_y     <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_pending      <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_addr         <= w_addr_nxt;
            r_rd_addr      <= w_rd_addr_nxt;
            r_sample_x     <= w_sample_x_nxt;
            r_sample_y     <= w_sample_y_nxt;
            r_sample_valid <= w_valid_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_pending      <= w_pending_nxt;
            r_overrun      <= w_overrun_nxt;
        end
    end

    assign bus.rd_addr      = r_rd_addr;
    assign bus.sample_valid = r_sample_valid;
    assign bus.sample_x     = r_sample_x;
    assign bus.sample_y     = r_sample_y;
    assign bus.busy         = r_busy;
    assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_trigger_buffer_reader.sv
// Directed bench for trigger_buffer_reader: RAM model with data[i]=16*i (addr 7 = 4095),
// fixed and random plotter back-pressure, queued/dropped captures, stray frame_start and reset.
module tb_trigger_buffer_reader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned Y_W    = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    trigger_buffer_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .Y_W(Y_W)) bus ();

    trigger_buffer_reader #(
        .DEPTH(256), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .Y_W(Y_W), .Y_SHIFT(3), .Y_OFFSET(100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] mem [256];

    // Synchronous RAM: data one cycle after address.
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    int n_tests = 0;
    int n_fail  = 0;
    logic [Y_W-1:0] got_y7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [Y_W-1:0] exp_y(input int i);
        logic [DATA_W-1:0] d;
        d = mem[i];
`ifdef TRIG_READ_INVERT_Y_EN
        d = 12'hFFF - d;
`endif
        return 10'(32'd100 + 32'(d >> 3));
    endfunction

    // Accept points first..last in order; optionally pulse capture_done (1) or frame_start (2)
    // when a given x is on the bus.
    task automatic recv(input int first, input int last, input bit rand_ready,
                        input int inj_x, input int inj_kind, input int inj2_x, input int inj2_kind);
        int exp_x;
        bit done;
        bit hold;
        bit r;
        bit f1;
        bit f2;
        logic [ADDR_W-1:0] hx;
        logic [Y_W-1:0] hy;
        exp_x = first;
        done = 1'b0;
        hold = 1'b0;
        f1 = 1'b0;
        f2 = 1'b0;
        hx = '0;
        hy = '0;
        for (int c = 0; c < (last - first + 1) * 12 + 40 && !done; c++) begin
            @(negedge clk);
            bus.capture_done = 1'b0;
            bus.frame_start  = 1'b0;
            if (hold) begin
                check("hold_valid", 32'(bus.sample_valid), 32'd1);
                check("hold_x", 32'(bus.sample_x), 32'(hx));
                check("hold_y", 32'(bus.sample_y), 32'(hy));
            end
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.sample_ready = r;
            if (bus.sample_valid) begin
                if (!f1 && inj_kind != 0 && 32'(bus.sample_x) == inj_x) begin
                    f1 = 1'b1;
                    if (inj_kind == 1) bus.capture_done = 1'b1;
                    else bus.frame_start = 1'b1;
                end
                if (!f2 && inj2_kind != 0 && 32'(bus.sample_x) == inj2_x) begin
                    f2 = 1'b1;
                    if (inj2_kind == 1) bus.capture_done = 1'b1;
                    else bus.frame_start = 1'b1;
                end
            end
            hold = bus.sample_valid && !r;
            hx = bus.sample_x;
            hy = bus.sample_y;
            if (bus.sample_valid && r) begin
                check("x_order", 32'(bus.sample_x), 32'(exp_x));
                check("y_value", 32'(bus.sample_y), 32'(exp_y(exp_x)));
                if (exp_x == 7) got_y7 = bus.sample_y;
                if (exp_x == last) done = 1'b1;
                exp_x++;
            end
        end
        check("stream_done", 32'(done), 32'd1);
        @(negedge clk);
        bus.capture_done = 1'b0;
        bus.frame_start  = 1'b0;
        bus.sample_ready = 1'b0;
    endtask

    initial begin
        bool_init: begin
            bus.capture_done = 1'b0;
            bus.frame_start  = 1'b0;
            bus.sample_ready = 1'b0;
            got_y7 = '0;
            for (int i = 0; i < 256; i++) mem[i] = 12'(16 * i);
            mem[7] = 12'hFFF;
        end

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_x", 32'(bus.sample_x), 32'd0);
        check("rst_y", 32'(bus.sample_y), 32'd0);
        rst = 1'b0;

        // frame_start while IDLE is ignored
        @(negedge clk); bus.frame_start = 1'b1;
        @(negedge clk); bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_fs_busy", 32'(bus.busy), 32'd0);
        check("idle_fs_valid", 32'(bus.sample_valid), 32'd0);

        // Arm; a second capture while ARMED is ignored
        bus.capture_done = 1'b1;
        @(negedge clk); bus.capture_done = 1'b0;
        check("armed_busy", 32'(bus.busy), 32'd1);
        @(negedge clk); bus.capture_done = 1'b1;
        @(negedge clk); bus.capture_done = 1'b0;
        repeat (3) @(negedge clk);
        check("armed_wait_valid", 32'(bus.sample_valid), 32'd0);

        // Stream 1: ready held high, stray frame_start at x=30; two-cycle latency
        bus.frame_start = 1'b1;
        @(negedge clk); bus.frame_start = 1'b0;
        check("lat_c1_valid", 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        check("lat_c2_valid", 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        check("lat_c3_valid", 32'(bus.sample_valid), 32'd1);
        check("lat_x0", 32'(bus.sample_x), 32'd0);
        check("lat_y0", 32'(bus.sample_y), 32'(exp_y(0)));
        recv(0, 255, 1'b0, 30, 2, -1, 0);
`ifdef TRIG_READ_INVERT_Y_EN
        check("y_at_addr7", 32'(got_y7), 32'd100);
`else
        check("y_at_addr7", 32'(got_y7), 32'd611);
`endif
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_valid", 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        check("end1_busy", 32'(bus.busy), 32'd0);
        check("end1_overrun", 32'(bus.overrun), 32'd0);
        check("end1_rd_addr_hold", 32'(bus.rd_addr), 32'd255);

        // Stream 2: random ready, captures at x=50 (queued) and x=60 (dropped)
        bus.capture_done = 1'b1;
        @(negedge clk); bus.capture_done = 1'b0;
        bus.frame_start = 1'b1;
        @(negedge clk); bus.frame_start = 1'b0;
        recv(0, 255, 1'b1, 50, 1, 60, 1);
        check("s2_done_valid", 32'(bus.sample_valid), 32'd0);
        check("s2_overrun", 32'(bus.overrun), 32'd1);
        @(negedge clk);
        check("s2_rearmed_busy", 32'(bus.busy), 32'd1);
        repeat (5) @(negedge clk);
        check("s2_wait_valid", 32'(bus.sample_valid), 32'd0);

        // Stream 3: queued capture consumed on the next frame
        bus.frame_start = 1'b1;
        @(negedge clk); bus.frame_start = 1'b0;
        recv(0, 255, 1'b0, 100, 2, -1, 0);
        @(negedge clk);
        check("s3_idle_busy", 32'(bus.busy), 32'd0);
        check("s3_overrun_sticky", 32'(bus.overrun), 32'd1);

        // capture_done and frame_start together in IDLE: arm only
        bus.capture_done = 1'b1;
        bus.frame_start  = 1'b1;
        @(negedge clk);
        bus.capture_done = 1'b0;
        bus.frame_start  = 1'b0;
        repeat (4) @(negedge clk);
        check("same_cycle_busy", 32'(bus.busy), 32'd1);
        check("same_cycle_valid", 32'(bus.sample_valid), 32'd0);

        // Stream 4: reset while x=120 is presented
        bus.frame_start = 1'b1;
        @(negedge clk); bus.frame_start = 1'b0;
        recv(0, 119, 1'b0, -1, 0, -1, 0);
        for (int c = 0; c < 10 && !bus.sample_valid; c++) @(negedge clk);
        check("pre_rst_valid", 32'(bus.sample_valid), 32'd1);
        check("pre_rst_x", 32'(bus.sample_x), 32'd120);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.sample_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_overrun", 32'(bus.overrun), 32'd0);
        check("mid_rst_x", 32'(bus.sample_x), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        // Stream 5: fresh capture restarts at x=0
        bus.capture_done = 1'b1;
        @(negedge clk); bus.capture_done = 1'b0;
        bus.frame_start = 1'b1;
        @(negedge clk); bus.frame_start = 1'b0;
        recv(0, 255, 1'b1, -1, 0, -1, 0);
        @(negedge clk);
        check("end5_busy", 32'(bus.busy), 32'd0);
        check("end5_overrun", 32'(bus.overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
